// File: rtl/gc_response_rx.sv
// GameCube controller reply receiver: pulse-width bit decoder with stop-bit
// stripping. Delivers the data bits LSB-first (first wire bit in rx_data[0]).
//
// state       | meaning
// S_IDLE      | waiting for a falling edge with enable high
// S_LOW       | line low, timing the pulse
// S_HIGH      | line high between bits, watching for end of frame
// S_WAIT_HIGH | frame discarded, waiting for the line to go quiet
module gc_response_rx #(
  parameter int CLKS_PER_US = 100,
  parameter int ONE_MAX_US  = 2,
  parameter int LOW_MAX_US  = 5,
  parameter int IDLE_US     = 6,
  parameter int MAX_BITS    = 64
) (
  input  logic                clk100mhz,
  input  logic                rst,
  input  logic                data_in,
  input  logic                enable,
  output logic [MAX_BITS-1:0] rx_data,
  output logic [6:0]          rx_bits,
  output logic                rx_valid,
  output logic                rx_error,
  output logic                busy
);

  localparam int ONE_CNT  = ONE_MAX_US * CLKS_PER_US;
  localparam int LOW_CNT  = LOW_MAX_US * CLKS_PER_US;
  localparam int IDLE_CNT = IDLE_US * CLKS_PER_US;
  localparam int SAT_CNT  = ((LOW_MAX_US > IDLE_US) ? LOW_MAX_US : IDLE_US) * CLKS_PER_US;
  localparam int CW       = $clog2(SAT_CNT + 1);

  // The counter is cleared in the cycle that acts on an edge, so a pulse of
  // W cycles leaves the counter at W-1; all limits are compared one lower.
  localparam logic [CW-1:0] ONE_LIM  = CW'(ONE_CNT - 1);
  localparam logic [CW-1:0] LOW_LIM  = CW'(LOW_CNT - 1);
  localparam logic [CW-1:0] IDLE_LIM = CW'(IDLE_CNT - 1);
  localparam logic [CW-1:0] SAT_LIM  = CW'(SAT_CNT);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT_HIGH} state_t;

  state_t            state, state_n;
  logic              sync1, sync2, line_prev;
  logic              edge_rise, edge_fall, any_edge;
  logic [CW-1:0]     cnt;
  logic [MAX_BITS:0] shreg;
  logic [6:0]        bitcnt;
  logic              clr_frame, store_bit, bit_val, valid_n, error_n;
  logic              stop_bit;
  logic [MAX_BITS-1:0] stop_mask;

  assign edge_rise = sync2 & ~line_prev;
  assign edge_fall = ~sync2 & line_prev;
  assign any_edge  = sync2 ^ line_prev;
  assign busy      = (state != S_IDLE);
  assign stop_bit  = shreg[bitcnt - 7'd1];
  assign stop_mask = {{(MAX_BITS-1){1'b0}}, 1'b1} << (bitcnt - 7'd1);

  always_comb begin
    state_n   = state;
    clr_frame = 1'b0;
    store_bit = 1'b0;
    bit_val   = (cnt < ONE_LIM);
    valid_n   = 1'b0;
    error_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && edge_fall) begin
          state_n   = S_LOW;
          clr_frame = 1'b1;
        end
      end
      S_LOW: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (cnt >= LOW_LIM) begin
          error_n = 1'b1;
          state_n = S_WAIT_HIGH;
        end else if (edge_rise) begin
          if (bitcnt > 7'(MAX_BITS)) begin
            error_n = 1'b1;
            state_n = S_WAIT_HIGH;
          end else begin
            store_bit = 1'b1;
            state_n   = S_HIGH;
          end
        end
      end
      S_HIGH: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (edge_fall) begin
          state_n = S_LOW;
        end else if (cnt >= IDLE_LIM) begin
          if (!stop_bit || bitcnt == 7'd1) error_n = 1'b1;
          else                             valid_n = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        // A saturated count from a long low must not end the wait on the rise.
        if (sync2 && !any_edge && cnt >= IDLE_LIM) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
      cnt       <= '0;
      state     <= S_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      rx_data   <= '0;
      rx_bits   <= '0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      sync1     <= data_in;
      sync2     <= sync1;
      line_prev <= sync2;
      if (any_edge)            cnt <= '0;
      else if (cnt != SAT_LIM) cnt <= cnt + CW'(1);
      state    <= state_n;
      rx_valid <= valid_n;
      rx_error <= error_n;
      if (clr_frame) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else if (store_bit) begin
        shreg[bitcnt] <= bit_val;
        bitcnt        <= bitcnt + 7'd1;
      end
      if (valid_n) begin
        rx_data <= shreg[MAX_BITS-1:0] & ~stop_mask;
        rx_bits <= bitcnt - 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_gc_response_rx.sv
// Bench for gc_response_rx: pulse-list frames checked against a reference
// model that decodes the pulse widths directly from the bus timing rules.
module tb_gc_response_rx;

  localparam int ONE_CNT  = 200;
  localparam int LOW_CNT  = 500;
  localparam int IDLE_CNT = 600;
  localparam int TAIL     = 700;

  logic        clk100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        data_in = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] rx_data;
  logic [6:0]  rx_bits;
  logic        rx_valid, rx_error, busy;

  int checks = 0, errors = 0, cyc = 0;
  int n_valid = 0, n_err = 0, n_both = 0, t_valid = 0, t_err = 0;
  int q_low[$], q_high[$];
  int t_rise = 0, t_long = -1;
  logic [63:0] exp_data = '0;
  logic [6:0]  exp_bits = '0;
  bit exp_v, exp_e, exp_long;

  gc_response_rx dut (
    .clk100mhz(clk100mhz), .rst(rst), .data_in(data_in), .enable(enable),
    .rx_data(rx_data), .rx_bits(rx_bits), .rx_valid(rx_valid),
    .rx_error(rx_error), .busy(busy)
  );

  always #5 clk100mhz = ~clk100mhz;
  always @(posedge clk100mhz) cyc <= cyc + 1;

  always @(negedge clk100mhz) begin
    if (!rst) begin
      if (rx_valid) begin n_valid <= n_valid + 1; t_valid <= cyc; end
      if (rx_error) begin n_err <= n_err + 1; t_err <= cyc; end
      if (rx_valid && rx_error) n_both <= n_both + 1;
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk100mhz); #1; end
  endtask

  task automatic add_pulse(int lo, int hi);
    q_low.push_back(lo);
    q_high.push_back(hi);
  endtask

  // slow: 1 = 1us low / 3us high, 0 = 3us low / 1us high
  task automatic add_bit(bit b, bit fast);
    if (fast) add_pulse(b ? 80 : 260, 60);
    else      add_pulse(b ? 100 : 300, b ? 300 : 100);
  endtask

  task automatic add_rand_bits(int n);
    for (int i = 0; i < n; i++) add_bit(1'($urandom_range(0, 1)), 1'b1);
  endtask

  // Reference decode: walk the pulse widths in wire order.
  task automatic model();
    logic [64:0] wire_bits;
    int n;
    wire_bits = '0;
    n = 0;
    exp_v = 0; exp_e = 0; exp_long = 0;
    for (int i = 0; i < q_low.size(); i++) begin
      if (q_low[i] >= LOW_CNT) begin exp_e = 1; exp_long = 1; break; end
      if (n == 65) begin exp_e = 1; break; end
      wire_bits[n] = (q_low[i] < ONE_CNT);
      n++;
    end
    if (!exp_e) begin
      if (n < 2 || !wire_bits[n-1]) exp_e = 1;
      else begin
        exp_v = 1;
        exp_bits = 7'(n - 1);
        exp_data = '0;
        for (int k = 0; k < n - 1; k++) exp_data[k] = wire_bits[k];
      end
    end
  endtask

  task automatic drive_frame();
    t_long = -1;
    for (int i = 0; i < q_low.size(); i++) begin
      data_in = 1'b0;
      if (q_low[i] >= LOW_CNT && t_long < 0) t_long = cyc;
      tick(q_low[i]);
      data_in = 1'b1;
      t_rise = cyc;
      tick(q_high[i]);
    end
    q_low.delete();
    q_high.delete();
  endtask

  task automatic run_frame(string tag);
    int v0, e0, b0;
    v0 = n_valid; e0 = n_err; b0 = n_both;
    q_high[q_high.size() - 1] = TAIL;
    model();
    drive_frame();
    chk({tag, "_nvalid"}, 64'(n_valid - v0), 64'(exp_v));
    chk({tag, "_nerr"},   64'(n_err - e0),   64'(exp_e));
    chk({tag, "_both"},   64'(n_both - b0),  64'd0);
    chk({tag, "_bits"},   64'(rx_bits),      64'(exp_bits));
    chk({tag, "_data"},   rx_data,           exp_data);
    chk({tag, "_busy"},   64'(busy),         64'd0);
    // data_in changes just after edge t; the first edge sampling it is t+1
    if (exp_v)    chk({tag, "_vlat"}, 64'(t_valid - t_rise - 1), 64'(2 + IDLE_CNT));
    if (exp_long) chk({tag, "_elat"}, 64'(t_err - t_long - 1),   64'(2 + LOW_CNT));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_data"},  rx_data,        64'd0);
    chk({tag, "_bits"},  64'(rx_bits),   64'd0);
    chk({tag, "_valid"}, 64'(rx_valid),  64'd0);
    chk({tag, "_error"}, 64'(rx_error),  64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] id_word;
    int v0, e0, nb, lo;
    tick(5);
    chk_zero("reset");
    rst = 1'b0;
    enable = 1'b1;
    tick(10);

    // ID reply 0x090000, MSB first, spec timing
    id_word = 24'h090000;
    for (int i = 23; i >= 0; i--) add_bit(id_word[i], 1'b0);
    add_bit(1'b1, 1'b0);
    run_frame("id");
    chk("id_low8", 64'(rx_data[7:0]), 64'b10010000);

    for (int i = 0; i < 64; i++) add_bit(1'((i % 2) == 0), 1'b1);
    add_bit(1'b1, 1'b1);
    run_frame("btn");
    chk("btn_const", rx_data, 64'h5555_5555_5555_5555);

    add_rand_bits(8);
    add_pulse(600, 60);
    run_frame("longlow");

    add_rand_bits(24);
    add_bit(1'b0, 1'b1);
    run_frame("stop0");

    add_pulse(199, 60); add_pulse(200, 60); add_pulse(499, 60); add_bit(1'b1, 1'b1);
    run_frame("widths");

    add_rand_bits(3);
    add_pulse(500, 60);
    run_frame("low500");

    add_bit(1'b1, 1'b1);
    run_frame("nodata");

    for (int i = 0; i < 65; i++) add_pulse(60, 30);
    run_frame("full64");

    for (int i = 0; i < 66; i++) add_pulse(60, 30);
    run_frame("over65");

    // enable dropped mid-reply, then host traffic with enable low
    v0 = n_valid; e0 = n_err;
    add_rand_bits(10);
    drive_frame();
    enable = 1'b0;
    tick(1);
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) add_bit(1'b1, 1'b1);
    drive_frame();
    chk("abort_busy2", 64'(busy), 64'd0);
    tick(TAIL);
    chk("abort_nvalid", 64'(n_valid - v0), 64'd0);
    chk("abort_nerr",   64'(n_err - e0),   64'd0);
    chk("abort_bits",   64'(rx_bits),      64'(exp_bits));
    chk("abort_data",   rx_data,           exp_data);
    enable = 1'b1;
    tick(5);
    add_rand_bits(24);
    add_bit(1'b1, 1'b1);
    run_frame("after_abort");

    // reset in the middle of bit 12
    add_rand_bits(11);
    drive_frame();
    data_in = 1'b0;
    tick(40);
    rst = 1'b1;
    tick(2);
    data_in = 1'b1;
    tick(3);
    chk_zero("midrst");
    exp_data = '0;
    exp_bits = '0;
    rst = 1'b0;
    tick(10);
    chk("midrst_idle", 64'(busy), 64'd0);
    add_rand_bits(24);
    add_bit(1'b1, 1'b1);
    run_frame("after_rst");

    for (int f = 0; f < 8; f++) begin
      nb = $urandom_range(1, 12);
      for (int i = 0; i < nb; i++) begin
        lo = ($urandom_range(0, 19) == 0) ? $urandom_range(500, 540) : $urandom_range(50, 480);
        add_pulse(lo, $urandom_range(20, 150));
      end
      if ($urandom_range(0, 5) == 0) add_pulse($urandom_range(200, 480), 60);
      else                           add_pulse($urandom_range(50, 199), 60);
      run_frame($sformatf("rand%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gc_response_rx.md
Name: gc_response_rx

Overview:
- Receiver for the GameCube single-wire controller bus.
- Decodes the controller's reply after each host command:
  - 24-bit ID/status reply to 0x00.
  - 64-bit button report to 0x400302.
- Samples the shared open-drain data pin, classifies each bit by its low-pulse width, and strips the stop bit.
- Delivers a frame with bit count to the controller-state logic that consumes the wavebird ID and button status.

Parameters:
- CLKS_PER_US, 100: clock cycles per microsecond (100 MHz clock).
- ONE_MAX_US, 2: a low pulse shorter than this many µs decodes as 1; otherwise 0.
- LOW_MAX_US, 5: a low pulse this long or longer is a framing error.
- IDLE_US, 6: line continuously high this long ends the frame.
- MAX_BITS, 64: maximum data bits per frame, excluding the stop bit.

Ports:
- clk100mhz  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous reset, active-high.
- data_in  input  1  raw bus pin. High-Z is read as 1 via the external pull-up.
- enable  input  1  listen window. Driven low while the host transmitter is sending.
- rx_data  output  64  received bits. First bit on the wire lands in rx_data[0], bit k in rx_data[k]. Unused upper bits are 0.
- rx_bits  output  7  number of data bits in rx_data, 0..64.
- rx_valid  output  1  one-cycle pulse: rx_data/rx_bits are updated and valid.
- rx_error  output  1  one-cycle pulse: frame discarded.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (async, rst=1):
  - State IDLE; all counters 0.
  - rx_data=0, rx_bits=0, rx_valid=0, rx_error=0, busy=0.
  - The synchronizer flops are set to 1.
- Input conditioning: data_in passes through a 2-flop synchronizer. All edges are detected on the synchronized value (2-cycle latency).
- Timing counter: a single cycle counter, reset on every edge. It saturates at (LOW_MAX_US>IDLE_US ? LOW_MAX_US : IDLE_US)*CLKS_PER_US and does not wrap.
- State IDLE:
  - busy=0.
  - A falling edge while enable=1 → LOW; clear the shift register and bit counter.
  - Falling edges while enable=0 are ignored.
- State LOW (line low):
  - Counter reaches LOW_MAX_US*CLKS_PER_US → rx_error pulse, then WAIT_HIGH.
  - Rising edge → classify the bit: count < ONE_MAX_US*CLKS_PER_US gives 1, else 0.
  - Store the bit at index bitcnt; bitcnt++; go to HIGH.
  - Storing bit index MAX_BITS+1 or beyond (the 66th bit) → rx_error pulse, then WAIT_HIGH.
- State HIGH (line high):
  - Falling edge → LOW.
  - Counter reaches IDLE_US*CLKS_PER_US → end of frame. The last stored bit is the stop bit.
    - Error if the stop bit is 0 or bitcnt==1 (no data bits): rx_error pulse.
    - Otherwise rx_valid pulse with rx_bits=bitcnt-1 and rx_data = data bits with the stop-bit position cleared.
    - Either way, go to IDLE.
- State WAIT_HIGH: wait until the line has been high for IDLE_US, then IDLE. No outputs change.
- enable deasserted in LOW or HIGH: abort to IDLE immediately. No rx_valid, no rx_error; rx_data/rx_bits are retained.
- Output holding:
  - rx_data and rx_bits change only in the cycle rx_valid is asserted; they hold until the next valid frame.
  - rx_valid and rx_error are never high together.
- Latency: rx_valid occurs 2 + IDLE_US*CLKS_PER_US cycles after the stop bit's rising edge on data_in.
- Reset mid-frame: immediate return to the reset values. The next frame requires a fresh falling edge with enable=1.

Test Plan:
- Stimulus: 24-bit reply 0x090000 MSB-first on the wire (bit=1: 1µs low/3µs high; bit=0: 3µs low/1µs high), then stop bit 1.
  - Response: one rx_valid, rx_bits=24, rx_data[7:0]=8'b10010000, rx_data[63:8]=0.
- Stimulus: 64-bit button frame, alternating 1,0 starting with 1, plus stop bit.
  - Response: rx_bits=64, rx_data=64'h5555_5555_5555_5555.
- Stimulus: 8 bits, then a 6µs low pulse.
  - Response: rx_error pulse at 5µs into the low; no rx_valid; back to IDLE after 6µs high.
- Stimulus: 24 bits, then stop bit 0 (3µs low), then idle.
  - Response: rx_error; rx_data/rx_bits still hold the previous frame.
- Stimulus: drop enable after 10 bits of a 24-bit reply; then send a full 24-bit reply with enable=1.
  - Response: no pulses for the aborted reply; the second reply decodes normally with rx_bits=24.
- Stimulus: assert rst during bit 12, release, then send a clean 24-bit reply.
  - Response: outputs zero during reset; the subsequent frame gives rx_valid with rx_bits=24.
